sine_sweep_ctrl: RTL

Frequency-sweep sequencer for the pure sine generator. It holds the sweep configuration in a small register file written byte-wise from the top-level IO pins. On a start pulse it drives a sequence of frequency tuning words (FTW) to the generator's phase accumulator. It sits between the tt_um top-level pin decode and the phase-accumulator/sine-LUT datapath.

---
 rtl/sine_sweep_ctrl_pkg.sv | 36 +++
 rtl/sine_sweep_ctrl_regfile.sv | 68 ++++++
 rtl/sine_sweep_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sine_sweep_ctrl_pkg.sv
// Shared definitions for the sine sweep controller.
// Holds the FSM state encoding, the config register map, the mode bit
// positions and a byte-merge helper used by the register file.
package sine_ctrl_pkg;

    localparam int unsigned FTW_W_DEF   = 16;
    localparam int unsigned DWELL_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [2:0] ADDR_START_LO = 3'd0;
    localparam logic [2:0] ADDR_START_HI = 3'd1;
    localparam logic [2:0] ADDR_STOP_LO  = 3'd2;
    localparam logic [2:0] ADDR_STOP_HI  = 3'd3;
    localparam logic [2:0] ADDR_STEP     = 3'd4;
    localparam logic [2:0] ADDR_DWELL_LO = 3'd5;
    localparam logic [2:0] ADDR_DWELL_HI = 3'd6;
    localparam logic [2:0] ADDR_MODE     = 3'd7;

    localparam int unsigned MODE_LOOP     = 0;
    localparam int unsigned MODE_PINGPONG = 1;

    // Replace the low or high byte of a 16-bit value.
    function automatic logic [15:0] merge_byte(logic [15:0] cur, logic [7:0] b, logic hi);
        logic [15:0] res;
        res = hi ? {b, cur[7:0]} : {cur[15:8], b};
        return res;
    endfunction

endpackage

// File: rtl/sine_sweep_ctrl_regfile.sv
// Byte-writable sweep configuration registers with a shadow copy.
// Ports: clk/rst_n/ena; cfg_we/cfg_addr/cfg_data byte write port;
// load captures the live registers into the shadow set; sh_* are the
// shadow values seen by the sweep FSM.
module sweep_regfile
    import sine_ctrl_pkg::*;
#(
    parameter int unsigned FTW_W   = FTW_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [7:0]         cfg_data,
    input  logic               load,
    output logic [FTW_W-1:0]   sh_start,
    output logic [FTW_W-1:0]   sh_stop,
    output logic [7:0]         sh_step,
    output logic [DWELL_W-1:0] sh_dwell,
    output logic [1:0]         sh_mode
);

    logic [FTW_W-1:0]   start_r;
    logic [FTW_W-1:0]   stop_r;
    logic [7:0]         step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [1:0]         mode_r;

    // Live registers take byte writes; shadow captures the pre-write values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r  <= '0;
            stop_r   <= '0;
            step_r   <= '0;
            dwell_r  <= '0;
            mode_r   <= '0;
            sh_start <= '0;
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
            sh_mode  <= '0;
        end else if (ena) begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_START_LO: start_r <= FTW_W'(merge_byte(16'(start_r), cfg_data, 1'b0));
                    ADDR_START_HI: start_r <= FTW_W'(merge_byte(16'(start_r), cfg_data, 1'b1));
                    ADDR_STOP_LO:  stop_r  <= FTW_W'(merge_byte(16'(stop_r), cfg_data, 1'b0));
                    ADDR_STOP_HI:  stop_r  <= FTW_W'(merge_byte(16'(stop_r), cfg_data, 1'b1));
                    ADDR_STEP:     step_r  <= cfg_data;
                    ADDR_DWELL_LO: dwell_r <= DWELL_W'(merge_byte(16'(dwell_r), cfg_data, 1'b0));
                    ADDR_DWELL_HI: dwell_r <= DWELL_W'(merge_byte(16'(dwell_r), cfg_data, 1'b1));
                    ADDR_MODE:     mode_r  <= cfg_data[1:0];
                    default:       ;
                endcase
            end
            if (load) begin
                sh_start <= start_r;
                sh_stop  <= stop_r;
                sh_step  <= step_r;
                sh_dwell <= dwell_r;
                sh_mode  <= mode_r;
            end
        end
    end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer driving tuning words to the sine generator.
// Ports: clk, rst_n (async active-low), ena (global freeze);
// cfg_we/cfg_addr/cfg_data config byte writes; start/abort one-cycle
// requests; ftw registered tuning word, ftw_upd one-cycle update strobe,
// busy sweep in progress, done sticky completion flag.
module sine_sweep_ctrl
    import sine_ctrl_pkg::*;
#(
    parameter int unsigned FTW_W   = FTW_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic             start,
    input  logic             abort,
    output logic [FTW_W-1:0] ftw,
    output logic             ftw_upd,
    output logic             busy,
    output logic             done
);

    state_e             state, state_nxt;
    logic [FTW_W-1:0]   ftw_nxt, tgt, tgt_nxt, tgt_swap;
    logic [DWELL_W-1:0] cnt, cnt_nxt, cnt_reload;
    logic               upd_nxt, busy_nxt, done_nxt, up, up_nxt;
    logic               accept_c, dwell_one;
    logic [FTW_W:0]     step_ext;

    logic [FTW_W-1:0]   sh_start, sh_stop;
    logic [7:0]         sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [1:0]         sh_mode;

    // Move one step toward the endpoint, clamping at it; widened so no wrap.
    function automatic logic [FTW_W-1:0] step_toward(logic [FTW_W-1:0] cur,
                                                     logic [FTW_W-1:0] end_v,
                                                     logic dir_up,
                                                     logic [FTW_W:0] stp);
        logic [FTW_W:0]   cur_x;
        logic [FTW_W:0]   end_x;
        logic [FTW_W-1:0] res;
        cur_x = {1'b0, cur};
        end_x = {1'b0, end_v};
        if (dir_up) begin
            res = (cur_x + stp >= end_x) ? end_v : FTW_W'(cur_x + stp);
        end else begin
            res = (cur_x <= end_x + stp) ? end_v : FTW_W'(cur_x - stp);
        end
        return res;
    endfunction

    // IDLE and DONE both count as not busy, so either accepts a start.
    assign accept_c = ena & start & ~abort & ((state == IDLE) | (state == DONE));

    sweep_regfile #(
        .FTW_W   (FTW_W),
        .DWELL_W (DWELL_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .load     (accept_c),
        .sh_start (sh_start),
        .sh_stop  (sh_stop),
        .sh_step  (sh_step),
        .sh_dwell (sh_dwell),
        .sh_mode  (sh_mode)
    );

    // Effective step/dwell; the update edge itself is one of the D cycles,
    // so the counter reloads with D-2 and D=1 goes straight back to STEP.
    always_comb begin
        step_ext   = (sh_step == 8'd0) ? (FTW_W+1)'(1) : (FTW_W+1)'(sh_step);
        dwell_one  = (sh_dwell <= DWELL_W'(1));
        cnt_reload = dwell_one ? '0 : sh_dwell - DWELL_W'(2);
        tgt_swap   = (tgt == sh_stop) ? sh_start : sh_stop;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt = state;
        ftw_nxt   = ftw;
        upd_nxt   = 1'b0;
        busy_nxt  = busy;
        done_nxt  = done;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        up_nxt    = up;
        if (abort) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state_nxt = IDLE;
                    if (start) begin
                        state_nxt = LOAD;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                    end
                end
                LOAD: begin
                    ftw_nxt   = sh_start;
                    tgt_nxt   = sh_stop;
                    up_nxt    = (sh_start <= sh_stop);
                    upd_nxt   = 1'b1;
                    cnt_nxt   = cnt_reload;
                    state_nxt = dwell_one ? STEP : DWELL;
                end
                DWELL: begin
                    if (cnt == '0) begin
                        state_nxt = STEP;
                    end else begin
                        cnt_nxt = cnt - DWELL_W'(1);
                    end
                end
                STEP: begin
                    upd_nxt   = 1'b1;
                    cnt_nxt   = cnt_reload;
                    state_nxt = dwell_one ? STEP : DWELL;
                    if (ftw != tgt) begin
                        ftw_nxt = step_toward(ftw, tgt, up, step_ext);
                    end else if (sh_mode[MODE_PINGPONG]) begin
                        tgt_nxt = tgt_swap;
                        up_nxt  = ~up;
                        ftw_nxt = step_toward(ftw, tgt_swap, ~up, step_ext);
                    end else if (sh_mode[MODE_LOOP]) begin
                        // Restart in place so the loop keeps the D-cycle spacing.
                        ftw_nxt = sh_start;
                        tgt_nxt = sh_stop;
                        up_nxt  = (sh_start <= sh_stop);
                    end else begin
                        upd_nxt   = 1'b0;
                        cnt_nxt   = cnt;
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; ena low freezes everything but the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ftw     <= '0;
            ftw_upd <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            tgt     <= '0;
            up      <= 1'b0;
        end else if (ena) begin
            state   <= state_nxt;
            ftw     <= ftw_nxt;
            ftw_upd <= upd_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            cnt     <= cnt_nxt;
            tgt     <= tgt_nxt;
            up      <= up_nxt;
        end else begin
            ftw_upd <= 1'b0;
        end
    end

endmodule
